// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch producer for the IF/ID pipeline register.
// Owns the PC and issues held word reads to instruction memory. Each fetched
// {pc, instruction} pair goes out with a combinational load strobe. A stalled
// response is parked in a one-entry hold buffer. Redirects that arrive while a
// read is outstanding are deferred until that read completes, and its data is
// dropped.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   imem_address/imem_read   request to instruction memory (address = pc)
//   imem_rdata/imem_resp     one-cycle response strobe with read data
//   stall_i                  IF/ID cannot load this cycle
//   redirect_i/redirect_pc_i taken branch/jump target from a later stage
//   pc_o/instruction_o       delivered pair, valid when load_o=1
//   load_o                   IF/ID load strobe
//
// Optional: define FETCH_PERF_CNT_EN to add fetch_count_o and stall_count_o.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        load_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count_o,
    output logic [31:0] stall_count_o
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] hold_buf, hold_buf_d;
    logic [31:0] pend_pc, pend_pc_d;
    logic [31:0] redirect_aligned;
    logic [31:0] pc_inc;

    assign redirect_aligned = redirect_pc_i & ~32'h3;
    assign pc_inc           = pc + 32'd4;   // wraps modulo 2^32
    assign imem_address     = pc;
    assign pc_o             = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            hold_buf <= 32'd0;
            pend_pc  <= 32'd0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            hold_buf <= hold_buf_d;
            pend_pc  <= pend_pc_d;
        end
    end

    always_comb begin
        state_d       = state;
        pc_d          = pc;
        hold_buf_d    = hold_buf;
        pend_pc_d     = pend_pc;
        imem_read     = 1'b0;
        load_o        = 1'b0;
        instruction_o = 32'd0;

        // Outputs stay quiet during reset; a response seen then is ignored
        // because the register block reloads on rst regardless.
        if (!rst) begin
            case (state)
                FETCH: begin
                    imem_read = 1'b1;
                    if (imem_resp) begin
                        if (redirect_i) begin
                            pc_d = redirect_aligned;
                        end else if (stall_i) begin
                            hold_buf_d = imem_rdata;
                            state_d    = HOLD;
                        end else begin
                            load_o        = 1'b1;
                            instruction_o = imem_rdata;
                            pc_d          = pc_inc;
                        end
                    end else if (redirect_i) begin
                        // The address must stay put until the outstanding
                        // read completes; park the target meanwhile.
                        pend_pc_d = redirect_aligned;
                        state_d   = FLUSH;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc_d    = redirect_aligned;
                        state_d = FETCH;
                    end else if (!stall_i) begin
                        load_o        = 1'b1;
                        instruction_o = hold_buf;
                        pc_d          = pc_inc;
                        state_d       = FETCH;
                    end
                end
                FLUSH: begin
                    imem_read = 1'b1;
                    if (imem_resp) begin
                        pc_d    = redirect_i ? redirect_aligned : pend_pc;
                        state_d = FETCH;
                    end else if (redirect_i) begin
                        pend_pc_d = redirect_aligned;   // latest redirect wins
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_o <= 32'd0;
            stall_count_o <= 32'd0;
        end else begin
            if (load_o) begin
                fetch_count_o <= fetch_count_o + 32'd1;
            end
            if ((state == HOLD) || ((state == FETCH) && imem_read && !imem_resp)) begin
                stall_count_o <= stall_count_o + 32'd1;
            end
        end
    end
`endif

endmodule
